j11bus_target: RTL

Bus responder for the J11 front-end: accepts the single-cycle `busreq` transactions issued by the CPU interface and completes each one with a single-cycle `busack`, carrying `busrdata`/`buserr`. It sits between the CPU interface and the rest of the system. It serves:
- local block RAM;
- the console switch/display register;
- general-purpose (GP) cycles;
- interrupt-acknowledge cycles.

All other I/O-page accesses are forwarded to a device port, guarded by a timeout.

---
 rtl/j11bus_target.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/j11bus_target.sv
// rtl/j11bus_target.sv - J11 bus responder: local RAM, console register, GP/IRQ cycles, device port
//
// Purpose
//   Completes each single-cycle busreq with a single-cycle busack. Serves local
//   block RAM, the console switch/display register, GP cycles and interrupt
//   acknowledge cycles; every other I/O-page access goes to the device port.
//
// Optional feature macro
//   J11BUS_TARGET_TIMEOUT_EN : when defined, a device cycle that receives no
//   devack within TIMEOUT cycles completes with buserr=1. When undefined, no
//   counter exists and DEVWAIT waits for devack indefinitely.
//
// Parameters
//   RAMAW    RAM word-address width (2^RAMAW 16-bit words)
//   TIMEOUT  device-port cycles allowed before bus error (2..65535)
//   GPRDATA  value returned on GP reads
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   busreq/buswr/busgp/busirq  transaction strobe and cycle type
//   busaddr/buswdata/buswstrb  byte address, write data, byte enables
//   busbs                      bank select, 2'b11 = I/O page
//   busack/busrdata/buserr     one-cycle completion with read data and error
//   sw/disp                    console switch input, display register
//   irqvec/irqack              IRQ vector input, acknowledge pulse
//   devreq/devwr/devaddr/devwdata/devwstrb  device request (held until done)
//   devack/devrdata/deverr     device completion

module j11bus_target #(
  parameter int          RAMAW   = 15,
  parameter int          TIMEOUT = 255,
  parameter logic [15:0] GPRDATA = 16'o173000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        busreq,
  input  logic        buswr,
  input  logic        busgp,
  input  logic        busirq,
  input  logic [21:0] busaddr,
  input  logic [15:0] buswdata,
  input  logic [1:0]  buswstrb,
  input  logic [1:0]  busbs,
  output logic        busack,
  output logic [15:0] busrdata,
  output logic        buserr,
  input  logic [15:0] sw,
  output logic [15:0] disp,
  input  logic [15:0] irqvec,
  output logic        irqack,
  output logic        devreq,
  output logic        devwr,
  output logic [12:0] devaddr,
  output logic [15:0] devwdata,
  output logic [1:0]  devwstrb,
  input  logic        devack,
  input  logic [15:0] devrdata,
  input  logic        deverr
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DEVWAIT,
    S_RESP
  } state_t;

  typedef enum logic [2:0] {
    K_RAM,
    K_CONSOLE,
    K_GP,
    K_IRQ,
    K_DEV,
    K_NXM
  } kind_t;

  state_t            state;
  kind_t             kind_d;
  kind_t             kind_q;
  logic              wr_q;
  logic [RAMAW-1:0]  ram_addr_q;
  logic [12:0]       dev_addr_q;
  logic [15:0]       wdata_q;
  logic [1:0]        wstrb_q;
  logic [15:0]       rdata_q;
  logic              rsel_ram;
  logic [15:0]       ram_q;
  logic              ram_we;

`ifdef J11BUS_TARGET_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LD = 16'(TIMEOUT);
  logic [15:0] cnt;
`endif

  // Cycle-type decode, highest priority first.
  always_comb begin
    kind_d = K_NXM;
    if (busirq)
      kind_d = K_IRQ;
    else if (busgp)
      kind_d = K_GP;
    else if (busbs == 2'b11 && busaddr[12:0] == 13'o17570)
      kind_d = K_CONSOLE;
    else if (busbs == 2'b11)
      kind_d = K_DEV;
    else if ((busaddr[21:1] >> RAMAW) == 21'd0)
      kind_d = K_RAM;
  end

  // Device port is a direct view of the latched request.
  assign devwr    = wr_q;
  assign devaddr  = dev_addr_q;
  assign devwdata = wdata_q;
  assign devwstrb = wstrb_q;

  // RAM read data lands in ram_q one cycle after ACCESS, i.e. in RESP, so the
  // response mux selects it directly instead of copying it a second time.
  assign busrdata = rsel_ram ? ram_q : rdata_q;

  // Writes are suppressed while rst is high so a dropped transaction leaves
  // memory untouched; the array itself is never reset.
  assign ram_we = (state == S_ACCESS) && (kind_q == K_RAM) && wr_q && !rst;

  logic [15:0] mem [0:(1<<RAMAW)-1];

  always_ff @(posedge clk) begin
    if (ram_we) begin
      if (wstrb_q[0]) mem[ram_addr_q][7:0]  <= wdata_q[7:0];
      if (wstrb_q[1]) mem[ram_addr_q][15:8] <= wdata_q[15:8];
    end
    ram_q <= mem[ram_addr_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      busack   <= 1'b0;
      irqack   <= 1'b0;
      devreq   <= 1'b0;
      buserr   <= 1'b0;
      rdata_q  <= 16'h0000;
      rsel_ram <= 1'b0;
      disp     <= 16'h0000;
`ifdef J11BUS_TARGET_TIMEOUT_EN
      cnt      <= 16'h0000;
`endif
    end else begin
      busack <= 1'b0;
      irqack <= 1'b0;
      case (state)
        S_IDLE: begin
          rsel_ram <= 1'b0;
          rdata_q  <= 16'h0000;
          buserr   <= 1'b0;
          if (busreq) begin
            kind_q     <= kind_d;
            wr_q       <= buswr;
            ram_addr_q <= busaddr[RAMAW:1];
            dev_addr_q <= busaddr[12:0];
            wdata_q    <= buswdata;
            wstrb_q    <= buswstrb;
            if (kind_d == K_DEV) begin
              state  <= S_DEVWAIT;
              devreq <= 1'b1;
`ifdef J11BUS_TARGET_TIMEOUT_EN
              cnt    <= TIMEOUT_LD;
`endif
            end else begin
              state <= S_ACCESS;
            end
          end
        end

        S_ACCESS: begin
          state    <= S_RESP;
          busack   <= 1'b1;
          buserr   <= 1'b0;
          rdata_q  <= 16'h0000;
          rsel_ram <= 1'b0;
          case (kind_q)
            K_RAM: rsel_ram <= !wr_q;
            K_CONSOLE: begin
              if (wr_q)
                disp <= {wstrb_q[1] ? wdata_q[15:8] : disp[15:8],
                         wstrb_q[0] ? wdata_q[7:0]  : disp[7:0]};
              else
                rdata_q <= sw;
            end
            K_GP: begin
              if (!wr_q) rdata_q <= GPRDATA;
            end
            K_IRQ: begin
              rdata_q <= irqvec;
              irqack  <= 1'b1;
            end
            default: buserr <= 1'b1;
          endcase
        end

        S_DEVWAIT: begin
          // devack is checked first so it wins over a same-cycle expiry.
          if (devack) begin
            state   <= S_RESP;
            devreq  <= 1'b0;
            busack  <= 1'b1;
            rdata_q <= devrdata;
            buserr  <= deverr;
          end
`ifdef J11BUS_TARGET_TIMEOUT_EN
          // cnt holds TIMEOUT in the first DEVWAIT cycle, so reaching 1 means
          // this is the TIMEOUT-th cycle without an ack.
          else if (cnt == 16'd1) begin
            state   <= S_RESP;
            devreq  <= 1'b0;
            busack  <= 1'b1;
            rdata_q <= 16'h0000;
            buserr  <= 1'b1;
          end else begin
            cnt <= cnt - 16'd1;
          end
`endif
        end

        S_RESP: begin
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
